prio_enc_rr: RTL
================

Name: prio_enc_rr

Overview:
- Parametrised successor to the team's fixed 4-to-2 one-hot encoder.
- Encodes an N-bit request vector into a binary index plus a one-hot grant.
- Selectable fixed-priority or round-robin arbitration.
- Registered output stage with valid/ready handshake and backpressure. Sits between request sources (IRQ lines, channel requests) and a downstream consumer that may stall.

Parameters:
- N, 8, number of request inputs; legal range 2..256; need not be a power of two.
- W, $clog2(N), derived localparam (not overridable); width of the binary code and of the RR pointer.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i is request i.
- req_valid  input  1  req is presented this cycle.
- req_ready  output  1  block accepts req this cycle; combinational, equals (!out_valid || out_ready).
- rr_mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin; sampled at accept.
- code_out  output  W  registered binary index of the granted request.
- onehot_out  output  N  registered one-hot grant; always equals 1<<code_out while out_valid.
- out_valid  output  1  code_out/onehot_out hold a valid grant.
- out_ready  input  1  consumer takes the output this cycle.
- err  output  1  multi-hot flag; see Optional Feature.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, code_out=0, onehot_out=0, err=0.
  - RR pointer ptr=0, state EMPTY.
  - Overrides all other inputs, including mid-transaction; any pending output is dropped.
- Accept condition: accept = req_valid && req_ready && (req != 0).
- Zero request: req_valid=1 with req=0 is consumed and discarded. No output, ptr unchanged, state unchanged.
- State machine, two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> FULL on out_ready && accept (back-to-back; output register reloaded).
  - FULL -> EMPTY on out_ready && !accept.
  - FULL holds all outputs unchanged while out_ready=0.
- Latency: grant visible on code_out/onehot_out exactly 1 cycle after the accept edge. Throughput is 1 grant per cycle while out_ready=1.
- Fixed mode (rr_mode=0):
  - g = highest set index of req, so req=0b1000 gives code 3, matching the legacy encoder for one-hot inputs.
  - ptr is not modified.
- Round-robin mode (rr_mode=1):
  - g = lowest set index i with i >= ptr.
  - If none exists, g = lowest set index overall (wrap).
  - On accept, ptr <= (g == N-1) ? 0 : g+1. Wraps at N-1, not at 2^W-1.
- Mode switch: takes effect at the next accept; ptr retains its value across fixed-mode periods.
- Arithmetic: all index math is W bits. For non-power-of-two N, ptr never exceeds N-1.
- The output register, ptr and err update only on accept or reset. req changes while req_ready=0 have no effect.

Optional Feature:
- Macro: PRIO_ENC_ONEHOT_CHECK_EN.
- Defined:
  - On accept, err <= 1 if popcount(req) > 1, else 0.
  - err is registered alongside code_out and valid under the same out_valid/out_ready rules.
  - Cleared by reset.
  - The grant is still produced normally.
- Undefined: err is tied to 0 and no popcount logic is synthesised. The port is always present.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with req_valid=1, req=0xFF -> out_valid=0, code_out=0, onehot_out=0, err=0, req_ready=1 after release.
2. Fixed mode, out_ready=1, req=0x04 for 1 cycle -> next cycle out_valid=1, code_out=2, onehot_out=0x04, err=0; following cycle out_valid=0.
3. Fixed mode, req=0x92 -> code_out=7, onehot_out=0x80; err=1 with macro defined, err=0 without.
4. RR mode, req=0x81 held valid, out_ready=1 for 4 accepts -> codes 0,7,0,7 on consecutive cycles; ptr sequence 1,0,1,0. Repeat with N=5, req=0x11 -> codes 0,4,0 and ptr wraps 4->0.
5. Backpressure:
   - Accept req=0x02, then hold out_ready=0 for 3 cycles while presenting req=0x10 -> req_ready=0, code_out stays 1.
   - Raise out_ready -> req_ready=1 that cycle, next cycle code_out=4.
6. Zero request and mid-op reset:
   - req_valid=1, req=0 -> out_valid stays 0, ptr unchanged.
   - Then with out_valid=1 and out_ready=0, assert rst -> next cycle out_valid=0, ptr=0.

Source files
------------

// File: rtl/prio_enc_rr.sv
// Priority encoder with fixed or round-robin arbitration and a registered valid/ready output stage.
// Optional multi-hot error flag: define PRIO_ENC_ONEHOT_CHECK_EN.
module prio_enc_rr #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  rr_mode,
  output logic [$clog2(N)-1:0]  code_out,
  output logic [N-1:0]          onehot_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state;
  logic [W-1:0]   ptr;
  logic [W-1:0]   fix_g;
  logic [W-1:0]   rr_lo;
  logic [W-1:0]   rr_hi;
  logic           hi_found;
  logic [W-1:0]   grant;
  logic [N-1:0]   onehot_next;
  logic           accept;

  assign out_valid = (state == FULL);
  assign req_ready = !out_valid || out_ready;
  assign accept    = req_valid && req_ready && (|req);

  // fix_g keeps the highest set bit; rr_hi the lowest at/above ptr; rr_lo the lowest overall.
  always_comb begin
    fix_g    = '0;
    rr_lo    = '0;
    rr_hi    = '0;
    hi_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) fix_g = W'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        rr_lo = W'(i);
        if (i >= int'(ptr)) begin
          rr_hi    = W'(i);
          hi_found = 1'b1;
        end
      end
    end
    if (rr_mode) grant = hi_found ? rr_hi : rr_lo;
    else         grant = fix_g;
    onehot_next        = '0;
    onehot_next[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      code_out   <= '0;
      onehot_out <= '0;
      ptr        <= '0;
    end else if (accept) begin
      state      <= FULL;
      code_out   <= grant;
      onehot_out <= onehot_next;
      if (rr_mode) ptr <= (grant == LAST) ? '0 : grant + W'(1);
    end else if (out_ready) begin
      state <= EMPTY;
    end
  end

`ifdef PRIO_ENC_ONEHOT_CHECK_EN
  logic err_q;
  assign err = err_q;

  // x & (x-1) is nonzero exactly when more than one bit is set.
  always_ff @(posedge clk) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= |(req & (req - N'(1)));
  end
`else
  assign err = 1'b0;
`endif

endmodule
